bf_ifetch: RTL and testbench

- Instruction fetch stage of the Brainfuck core. Sits between the instruction RAM and the decoder/execute unit.
- Drives the RAM address and read-enable. The RAM returns the byte one clock after the enable edge.
- Buffers returned bytes in a 2-entry FIFO and presents them to the decoder with a valid/ready handshake.
- Handles redirects for bracket jumps and detects end of program (a 0x00 byte).

---
 rtl/bf_pkg.sv | 19 +
 rtl/bf_ifetch_fifo.sv | 78 +++++++
 rtl/bf_ifetch.sv | 136 +++++++++++++
 tb/tb_bf_ifetch.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// ----------------------------------------------------------------------------
// bf_pkg
// Shared definitions for the Brainfuck core.
//   IA_WIDTH_DEFAULT : default instruction address width (2^11 byte program)
//   OP_END           : opcode byte that terminates a program
//   state_t          : fetch state encoding (ST_RUN / ST_STOP)
// ----------------------------------------------------------------------------
package bf_pkg;

    localparam int IA_WIDTH_DEFAULT = 11;

    localparam logic [7:0] OP_END = 8'h00;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_STOP = 1'b1
    } state_t;

endpackage : bf_pkg

// File: rtl/bf_ifetch_fifo.sv
// ----------------------------------------------------------------------------
// bf_ifetch_fifo
// Two-entry synchronous FIFO holding {instruction byte, address} pairs for the
// fetch stage. entry0 is always the head, so the head output holds its last
// value when the FIFO drains or is flushed.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write an entry
//   pop        : remove the head entry (ignored when empty)
//   flush      : discard all entries (wins over push and pop)
//   count      : number of valid entries (0..2)
//   head       : head entry data
// ----------------------------------------------------------------------------
module bf_ifetch_fifo #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic [1:0]       count_q;
    logic             do_pop;

    assign do_pop = pop && (count_q != 2'd0);

    // Shift-style storage: a pop moves entry1 forward into the head slot.
    // A push into a full FIFO cannot happen without a simultaneous pop
    // because the fetch issue rule never allows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0  <= '0;
            entry1  <= '0;
            count_q <= 2'd0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        entry0  <= din;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && do_pop) begin
                        entry0 <= din;
                    end else if (push) begin
                        entry1  <= din;
                        count_q <= 2'd2;
                    end else if (do_pop) begin
                        count_q <= 2'd0;
                    end
                end
                default: begin
                    if (do_pop) begin
                        entry0 <= entry1;
                        if (push) begin
                            entry1 <= din;
                        end else begin
                            count_q <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign count = count_q;
    assign head  = entry0;

endmodule : bf_ifetch_fifo

// File: rtl/bf_ifetch.sv
// ----------------------------------------------------------------------------
// bf_ifetch
// Instruction fetch stage of the Brainfuck core. Reads the instruction RAM
// (one-cycle read latency), buffers bytes in a 2-entry FIFO and hands them to
// the decoder with a valid/ready handshake. Handles bracket-jump redirects and
// stops fetching when the end-of-program byte (0x00) is captured.
//   clk, rst_n  : clock, asynchronous active-low reset
//   ia, ien     : RAM address (the PC) and combinational read-enable
//   id          : RAM read data, valid the cycle after an ien edge
//   insn,
//   insn_pc,
//   insn_valid  : FIFO head byte, its address, and head-valid
//   insn_ready  : decoder consumes the head this cycle
//   jump,
//   jump_target : one-cycle redirect request and its address
//   done        : program ended and every fetched byte has been consumed
// ----------------------------------------------------------------------------
module bf_ifetch
    import bf_pkg::*;
#(
    parameter int IA_WIDTH = IA_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [IA_WIDTH-1:0] ia,
    output logic                ien,
    input  logic [7:0]          id,
    output logic [7:0]          insn,
    output logic [IA_WIDTH-1:0] insn_pc,
    output logic                insn_valid,
    input  logic                insn_ready,
    input  logic                jump,
    input  logic [IA_WIDTH-1:0] jump_target,
    output logic                done
);

    localparam int FW = 8 + IA_WIDTH;

    state_t              state;
    state_t              state_next;
    logic [IA_WIDTH-1:0] pc;
    logic [IA_WIDTH-1:0] inflight_pc;
    logic                inflight;
    logic                done_q;
    logic                done_next;
    logic                push;
    logic                pop;
    logic [1:0]          count;
    logic [1:0]          count_next;
    logic [2:0]          occupancy;
    logic [FW-1:0]       head;

    assign insn_valid = (count != 2'd0);
    assign pop        = insn_valid && insn_ready;

    // Slots already committed (buffered plus in flight) after this cycle's
    // pop. Issuing only while this is below two keeps the FIFO from ever
    // overflowing, yet still allows one fetch per cycle when the decoder
    // consumes one byte per cycle.
    assign occupancy = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};

    // Gated by rst_n so the RAM sees no enable while reset is held.
    assign ien = rst_n && (state == ST_RUN) && !jump && (occupancy < 3'd2);

    // Next state, FIFO push and the registered done condition. A redirect
    // overrides any capture: the in-flight byte belongs to the old path.
    // In STOP the byte that was already in flight past the end marker is
    // dropped rather than presented.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        if (jump) begin
            state_next = ST_RUN;
        end else if ((state == ST_RUN) && inflight) begin
            if (id == OP_END) begin
                state_next = ST_STOP;
            end else begin
                push = 1'b1;
            end
        end
        if (jump) begin
            count_next = 2'd0;
        end else begin
            count_next = count + {1'b0, push} - {1'b0, pop};
        end
        done_next = (state_next == ST_STOP) && (count_next == 2'd0) && !ien;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // PC, in-flight tracking and done register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            done_q      <= 1'b0;
        end else begin
            if (jump) begin
                pc <= jump_target;
            end else if (ien) begin
                pc <= pc + 1'b1;
            end
            inflight <= ien;
            if (ien) begin
                inflight_pc <= pc;
            end
            done_q <= done_next;
        end
    end

    bf_ifetch_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (jump),
        .din   ({id, inflight_pc}),
        .count (count),
        .head  (head)
    );

    assign ia      = pc;
    assign insn    = head[FW-1 -: 8];
    assign insn_pc = head[IA_WIDTH-1:0];
    assign done    = done_q;

endmodule : bf_ifetch

// File: tb/tb_bf_ifetch.sv
// ----------------------------------------------------------------------------
// tb_bf_ifetch
// Self-checking bench for bf_ifetch: a streaming vector table, hand-written
// sequences for backpressure, redirects, wrap-around and asynchronous reset,
// and a randomized run checked against a program-walk reference model.
// ----------------------------------------------------------------------------
module tb_bf_ifetch;
    import bf_pkg::*;

    localparam int AW = 11;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] ia;
    logic          ien;
    logic [7:0]    id = 8'h00;
    logic [7:0]    insn;
    logic [AW-1:0] insn_pc;
    logic          insn_valid;
    logic          insn_ready;
    logic          jump;
    logic [AW-1:0] jump_target;
    logic          done;

    logic [7:0] mem [0:(1<<AW)-1];

    int vectors;
    int miscompares;

    typedef struct {
        logic          rdy;
        logic          jmp;
        logic [AW-1:0] tgt;
        logic [AW-1:0] ia;
        logic          ien;
        logic          valid;
        logic [7:0]    insn;
        logic [AW-1:0] pc;
        logic          done;
    } vec_t;

    vec_t tbl [9];

    bf_ifetch #(
        .IA_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ia          (ia),
        .ien         (ien),
        .id          (id),
        .insn        (insn),
        .insn_pc     (insn_pc),
        .insn_valid  (insn_valid),
        .insn_ready  (insn_ready),
        .jump        (jump),
        .jump_target (jump_target),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction RAM: one-cycle read latency, output held when not enabled.
    always @(posedge clk) begin
        if (ien) begin
            id <= mem[ia];
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time
    // unit later, well away from the rising edge.
    task automatic apply_stimulus(input logic rdy, input logic jmp, input logic [AW-1:0] tgt);
        insn_ready  = rdy;
        jump        = jmp;
        jump_target = tgt;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Leaves the bench at the falling edge where cycle 0 begins.
    task automatic do_reset();
        rst_n       = 1'b0;
        insn_ready  = 1'b0;
        jump        = 1'b0;
        jump_target = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = v;
        end
    endtask

    initial begin
        logic [AW-1:0] exp_pc;
        logic [AW-1:0] ia_seen [$];
        int            pulses;
        logic          rdy;
        logic          jmp;
        logic [AW-1:0] tgt;

        vectors     = 0;
        miscompares = 0;

        // ---------------- streaming table ----------------
        tbl[0] = '{1'b1, 1'b0, 11'h0, 11'h0, 1'b1, 1'b0, 8'h00, 11'h0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 11'h0, 11'h1, 1'b1, 1'b0, 8'h00, 11'h0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 11'h0, 11'h2, 1'b1, 1'b1, 8'h2B, 11'h0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 11'h0, 11'h3, 1'b1, 1'b1, 8'h2D, 11'h1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 11'h0, 11'h4, 1'b1, 1'b1, 8'h3E, 11'h2, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 11'h0, 11'h5, 1'b1, 1'b1, 8'h3C, 11'h3, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 11'h0, 11'h6, 1'b0, 1'b0, 8'h3C, 11'h3, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 11'h0, 11'h6, 1'b0, 1'b0, 8'h3C, 11'h3, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 11'h0, 11'h6, 1'b0, 1'b0, 8'h3C, 11'h3, 1'b1};

        fill_mem(8'h2E);
        mem[0] = 8'h2B;
        mem[1] = 8'h2D;
        mem[2] = 8'h3E;
        mem[3] = 8'h3C;
        mem[4] = 8'h00;
        mem[8'h11] = 8'h00;

        rst_n       = 1'b0;
        insn_ready  = 1'b0;
        jump        = 1'b0;
        jump_target = '0;
        @(negedge clk);
        #1;
        check_output("reset.ia", 32'(ia), 32'h0);
        check_output("reset.ien", 32'(ien), 32'h0);
        check_output("reset.valid", 32'(insn_valid), 32'h0);
        check_output("reset.insn", 32'(insn), 32'h0);
        check_output("reset.insn_pc", 32'(insn_pc), 32'h0);
        check_output("reset.done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(tbl[i].rdy, tbl[i].jmp, tbl[i].tgt);
            check_output($sformatf("stream[%0d].ia", i), 32'(ia), 32'(tbl[i].ia));
            check_output($sformatf("stream[%0d].ien", i), 32'(ien), 32'(tbl[i].ien));
            check_output($sformatf("stream[%0d].valid", i), 32'(insn_valid), 32'(tbl[i].valid));
            check_output($sformatf("stream[%0d].insn", i), 32'(insn), 32'(tbl[i].insn));
            check_output($sformatf("stream[%0d].insn_pc", i), 32'(insn_pc), 32'(tbl[i].pc));
            check_output($sformatf("stream[%0d].done", i), 32'(done), 32'(tbl[i].done));
            next_cycle();
        end

        // ---------------- jump out of STOP (cycle 9 onward) ----------------
        apply_stimulus(1'b1, 1'b1, 11'h010);
        check_output("stopjump.done_before", 32'(done), 32'h1);
        check_output("stopjump.ien_jump", 32'(ien), 32'h0);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 11'h0);
        check_output("stopjump.done_cleared", 32'(done), 32'h0);
        check_output("stopjump.ia", 32'(ia), 32'h010);
        check_output("stopjump.ien", 32'(ien), 32'h1);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 11'h0);
        check_output("stopjump.valid_gap", 32'(insn_valid), 32'h0);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 11'h0);
        check_output("stopjump.valid", 32'(insn_valid), 32'h1);
        check_output("stopjump.insn", 32'(insn), 32'h2E);
        check_output("stopjump.insn_pc", 32'(insn_pc), 32'h010);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 11'h0);
        check_output("stopjump.done_c13", 32'(done), 32'h0);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 11'h0);
        check_output("stopjump.done_c14", 32'(done), 32'h1);
        next_cycle();

        // ---------------- redirect while fetching at PC=5 ----------------
        fill_mem(8'h2B);
        for (int k = 0; k < 8; k++) begin
            mem[k] = 8'(8'h30 + k);
        end
        mem[11'h100] = 8'h5B;
        mem[11'h101] = 8'h5D;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            apply_stimulus(1'b1, 1'b0, 11'h0);
            next_cycle();
        end
        apply_stimulus(1'b1, 1'b1, 11'h100);
        check_output("jump.ia_at_jump", 32'(ia), 32'h5);
        check_output("jump.ien_at_jump", 32'(ien), 32'h0);
        check_output("jump.pop_pc", 32'(insn_pc), 32'h3);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 11'h0);
        check_output("jump.ia_target", 32'(ia), 32'h100);
        check_output("jump.ien_resume", 32'(ien), 32'h1);
        check_output("jump.valid_c6", 32'(insn_valid), 32'h0);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 11'h0);
        check_output("jump.valid_c7", 32'(insn_valid), 32'h0);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 11'h0);
        check_output("jump.valid_c8", 32'(insn_valid), 32'h1);
        check_output("jump.insn_c8", 32'(insn), 32'h5B);
        check_output("jump.pc_c8", 32'(insn_pc), 32'h100);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 11'h0);
        check_output("jump.insn_c9", 32'(insn), 32'h5D);
        check_output("jump.pc_c9", 32'(insn_pc), 32'h101);
        next_cycle();

        // ---------------- backpressure ----------------
        fill_mem(8'h2B);
        do_reset();
        pulses = 0;
        ia_seen.delete();
        for (int c = 0; c < 10; c++) begin
            apply_stimulus(1'b0, 1'b0, 11'h0);
            if (ien) begin
                pulses++;
                ia_seen.push_back(ia);
            end
            next_cycle();
        end
        check_output("bp.ien_pulses", 32'(pulses), 32'd2);
        if (ia_seen.size() >= 2) begin
            check_output("bp.ia0", 32'(ia_seen[0]), 32'h0);
            check_output("bp.ia1", 32'(ia_seen[1]), 32'h1);
        end
        exp_pc = '0;
        for (int c = 10; c < 30; c++) begin
            apply_stimulus(1'b1, 1'b0, 11'h0);
            if (insn_valid) begin
                check_output("bp.insn_pc", 32'(insn_pc), 32'(exp_pc));
                exp_pc = exp_pc + 1'b1;
            end
            next_cycle();
        end
        check_output("bp.pops", 32'(exp_pc), 32'd20);

        // ---------------- wrap-around ----------------
        fill_mem(8'h2E);
        mem[11'h7FF] = 8'h2B;
        mem[0]       = 8'h2D;
        mem[1]       = 8'h00;
        do_reset();
        apply_stimulus(1'b1, 1'b1, 11'h7FF);
        check_output("wrap.ien_jump", 32'(ien), 32'h0);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 11'h0);
        check_output("wrap.ia_7ff", 32'(ia), 32'h7FF);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 11'h0);
        check_output("wrap.ia_000", 32'(ia), 32'h000);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 11'h0);
        check_output("wrap.insn0", 32'(insn), 32'h2B);
        check_output("wrap.pc0", 32'(insn_pc), 32'h7FF);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 11'h0);
        check_output("wrap.insn1", 32'(insn), 32'h2D);
        check_output("wrap.pc1", 32'(insn_pc), 32'h000);
        next_cycle();

        // ---------------- asynchronous reset mid-operation ----------------
        fill_mem(8'h2B);
        do_reset();
        apply_stimulus(1'b0, 1'b0, 11'h0);
        next_cycle();
        apply_stimulus(1'b0, 1'b0, 11'h0);
        next_cycle();
        apply_stimulus(1'b0, 1'b1, 11'h055);
        check_output("areset.valid_before", 32'(insn_valid), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("areset.valid", 32'(insn_valid), 32'h0);
        check_output("areset.ien", 32'(ien), 32'h0);
        check_output("areset.done", 32'(done), 32'h0);
        check_output("areset.ia", 32'(ia), 32'h0);
        jump = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b0, 11'h0);
        check_output("areset.ien_after", 32'(ien), 32'h1);
        check_output("areset.ia_after", 32'(ia), 32'h0);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 11'h0);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 11'h0);
        check_output("areset.first_pc", 32'(insn_pc), 32'h0);
        check_output("areset.first_valid", 32'(insn_valid), 32'h1);
        next_cycle();

        // ---------------- randomized run against a program-walk model ----------------
        // The model only tracks the next address the decoder should receive:
        // consumed bytes must follow the program from the last redirect target,
        // and done may only be seen once that walk has reached an end marker.
        for (int i = 0; i < (1 << AW); i++) begin
            if ((i % 97) == 96 || $urandom_range(0, 15) == 0) begin
                mem[i] = 8'h00;
            end else begin
                mem[i] = 8'($urandom_range(1, 255));
            end
        end
        do_reset();
        exp_pc = '0;
        for (int c = 0; c < 4000; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            jmp = ($urandom_range(0, 59) == 0);
            tgt = AW'($urandom);
            apply_stimulus(rdy, jmp, tgt);
            if (insn_valid) begin
                check_output("rand.done_with_valid", 32'(done), 32'h0);
            end
            if (insn_valid && insn_ready) begin
                check_output("rand.insn_pc", 32'(insn_pc), 32'(exp_pc));
                check_output("rand.insn", 32'(insn), 32'(mem[exp_pc]));
                exp_pc = exp_pc + 1'b1;
            end
            if (done) begin
                check_output("rand.done_at_end", 32'(mem[exp_pc] == 8'h00), 32'h1);
                check_output("rand.ien_when_done", 32'(ien), 32'h0);
            end
            if (jump) begin
                exp_pc = jump_target;
            end
            next_cycle();
        end

        // Drain with the decoder always ready; the program must reach done.
        for (int c = 0; c < 3000 && !done; c++) begin
            apply_stimulus(1'b1, 1'b0, 11'h0);
            if (insn_valid) begin
                check_output("drain.insn_pc", 32'(insn_pc), 32'(exp_pc));
                check_output("drain.insn", 32'(insn), 32'(mem[exp_pc]));
                exp_pc = exp_pc + 1'b1;
            end
            next_cycle();
        end
        #1;
        check_output("drain.done", 32'(done), 32'h1);
        check_output("drain.at_end", 32'(mem[exp_pc] == 8'h00), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_bf_ifetch
